hilo_md_ctrl: RTL

//  Sequencer for the HI/LO register pair: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX,

---
 rtl/hilo_md_ctrl_pkg.sv | 37 +++
 rtl/hilo_md_ctrl_div_iter.sv | 89 ++++++++
 rtl/hilo_md_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hilo_md_ctrl_pkg.sv
// hilo_md_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   opcode and FSM state encodings, divide step count and the
//   64-bit multiply helper used by the sequencer's product pipeline.
package hilo_md_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_WB
    } md_state_e;

    localparam int unsigned DIV_STEPS = 32;

    // Full 64-bit product, two's complement when is_signed is set.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        is_signed);
        logic signed [63:0] sp;
        logic        [63:0] up;
        sp = $signed(a) * $signed(b);
        up = {32'd0, a} * {32'd0, b};
        return is_signed ? 64'(sp) : up;
    endfunction

endpackage

// File: rtl/hilo_md_ctrl_div_iter.sv
// div_iter
//   32-step restoring radix-2 divider, one quotient bit per cycle.
//   Signed operands are reduced to magnitudes on start; the sign fix is
//   applied combinationally to the final step so the result is ready in
//   the same cycle valid is high.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           load operands and begin (ignored if abort is high)
//   abort           stop an in-flight divide, no result produced
//   sgn             1 = DIV (signed), 0 = DIVU
//   a, b            dividend, divisor
//   quot, rem       sign-corrected quotient/remainder, meaningful when valid
//   valid           high during the last step cycle
module div_iter
    import hilo_md_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        valid
);

    localparam int unsigned CNT_W = $clog2(DIV_STEPS);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      q;       // dividend bits shift out the top, quotient bits shift in
    logic [31:0]      d;
    logic [32:0]      r;
    logic             neg_q;
    logic             neg_r;

    logic [33:0]      shifted;
    logic [33:0]      diff;
    logic             ge;
    logic [32:0]      r_nxt;
    logic [31:0]      q_nxt;
    logic [31:0]      a_abs;
    logic [31:0]      b_abs;

    always_comb begin
        shifted = {r, q[31]};
        diff    = shifted - {2'b00, d};
        ge      = ~diff[33];
        r_nxt   = ge ? diff[32:0] : shifted[32:0];
        q_nxt   = {q[30:0], ge};
        a_abs   = (sgn && a[31]) ? -a : a;
        b_abs   = (sgn && b[31]) ? -b : b;
    end

    assign valid = running && (cnt == CNT_W'(DIV_STEPS - 1));
    assign quot  = neg_q ? -q_nxt : q_nxt;
    assign rem   = neg_r ? -r_nxt[31:0] : r_nxt[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            q       <= '0;
            d       <= '0;
            r       <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            q       <= a_abs;
            d       <= b_abs;
            r       <= '0;
            neg_q   <= sgn & (a[31] ^ b[31]);
            neg_r   <= sgn & a[31];
        end else if (running) begin
            q   <= q_nxt;
            r   <= r_nxt;
            cnt <= cnt + 1'b1;
            if (valid)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl
//   HI/LO sequencer: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a
//   MUL_CYCLES multiply or a 32-step divide and drives the HI/LO write port
//   for one cycle in WB. busy stalls the pipeline; cancel aborts MUL/DIV.
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   op handshake (ready only in IDLE)
//   req_op, req_a, req_b  opcode and operands
//   cancel                flush: abort MUL/DIV, block acceptance in IDLE
//   busy, done            state != IDLE, one-cycle WB pulse
//   hi_we, lo_we          HI/LO write enables
//   wd_hi, wd_lo          HI/LO write data (from result registers)
module hilo_md_ctrl
    import hilo_md_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] wd_hi,
    output logic [31:0] wd_lo
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    md_state_e        state;
    logic [CNT_W-1:0] mul_cnt;
    logic [63:0]      mul_pipe [MUL_CYCLES];
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    logic             accept;
    logic             div_start;
    logic [31:0]      div_quot;
    logic [31:0]      div_rem;
    logic             div_valid;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_ready && req_valid && !cancel;
    assign div_start = accept && (req_op == OP_DIV || req_op == OP_DIVU);
    assign wd_hi     = res_hi;
    assign wd_lo     = res_lo;

    // The product is formed from the request operands on every edge and then
    // delayed MUL_CYCLES-1 more stages, so the last stage holds the product
    // of the accepted operands on the edge the FSM leaves MUL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_CYCLES; i++)
                mul_pipe[i] <= '0;
        end else begin
            mul_pipe[0] <= mul64(req_a, req_b, req_op == OP_MULT);
            for (int unsigned i = 1; i < MUL_CYCLES; i++)
                mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    div_iter u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .abort (cancel),
        .sgn   (req_op == OP_DIV),
        .a     (req_a),
        .b     (req_b),
        .quot  (div_quot),
        .rem   (div_rem),
        .valid (div_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            hi_we   <= 1'b0;
            lo_we   <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MULT, OP_MULTU: begin
                                mul_cnt <= '0;
                                state   <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: state <= ST_DIV;
                            OP_MTHI: begin
                                res_hi <= req_a;
                                hi_we  <= 1'b1;
                                done   <= 1'b1;
                                state  <= ST_WB;
                            end
                            OP_MTLO: begin
                                res_lo <= req_a;
                                lo_we  <= 1'b1;
                                done   <= 1'b1;
                                state  <= ST_WB;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (mul_cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        {res_hi, res_lo} <= mul_pipe[MUL_CYCLES-1];
                        hi_we <= 1'b1;
                        lo_we <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_WB;
                    end else begin
                        mul_cnt <= mul_cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (div_valid) begin
                        res_lo <= div_quot;
                        res_hi <= div_rem;
                        hi_we  <= 1'b1;
                        lo_we  <= 1'b1;
                        done   <= 1'b1;
                        state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    hi_we <= 1'b0;
                    lo_we <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
